packet_wrr_scheduler: RTL and testbench

PACKET_WRR_SCHEDULER -- requirements
Module: packet_wrr_scheduler

---
 rtl/packet_wrr_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_packet_wrr_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_wrr_scheduler.sv
// packet_wrr_scheduler: packet-level weighted round-robin arbiter.
// Each requester receives up to weight[i] packet grants per round (a weight
// of 0 counts as 1). A grant is held from the cycle after arbitration until
// the owner pulses fin. One GAP cycle follows, then the IDLE cycle that
// performs the next arbitration.
// Ports:
//   clock    - single clock, rising edge
//   reset    - asynchronous, active-low; deassertion passes through a 2-flop sync
//   req      - per-requester packet request (level)
//   fin      - per-requester end-of-packet pulse; only the current owner's bit is used
//   ready    - downstream can take a new packet; gates new grants only
//   weights  - per-requester credits per round, field i = weights[i*WW +: WW]
//   grant    - registered one-hot grant
//   grant_id - index of current owner (holds the last owner when idle)
//   busy     - a packet is currently granted
//   timeout  - one-cycle pulse when the watchdog aborts a packet
// Optional feature: define PKT_WATCHDOG_EN to include the TIMEOUT-cycle watchdog.
module packet_wrr_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned WW      = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    fin,
  input  logic            ready,
  input  logic [N*WW-1:0] weights,
  output logic [N-1:0]    grant,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [WW-1:0] credit_q [N];
  logic [WW-1:0] credit_d [N];
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    owner_q, owner_d;
  logic [N-1:0]  grant_q, grant_d;

  logic          hi_found, lo_found, found;
  logic [2:0]    hi_pick, lo_pick, pick;
  logic [WW-1:0] owner_credit;
  logic [2:0]    next_owner;
  logic          fin_owner;
  logic          expired;

  // grant_q is one-hot on the owner only while in GRANT, so this masks
  // fin down to the owner's bit without a variable index.
  assign fin_owner  = |(fin & grant_q);
  assign next_owner = (owner_q == 3'(N - 1)) ? 3'd0 : owner_q + 3'd1;

  // Round-robin search from ptr: the first eligible index at or above ptr
  // wins; otherwise wrap to the lowest eligible index below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && (credit_q[i] != '0)) begin
        if (3'(i) >= ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_pick  = 3'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_pick  = 3'(i);
        end
      end
    end
  end

  assign found = hi_found | lo_found;
  assign pick  = hi_found ? hi_pick : lo_pick;

  always_comb begin
    owner_credit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (3'(i) == owner_q) owner_credit = credit_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    grant_d  = '0;
    case (state_q)
      IDLE: begin
        if (sync_q[1] && ready && (req != '0)) begin
          if (found) begin
            state_d = GRANT;
            owner_d = pick;
            for (int unsigned i = 0; i < N; i++) grant_d[i] = (3'(i) == pick);
          end else begin
            for (int unsigned i = 0; i < N; i++) begin
              credit_d[i] = (weights[i*WW +: WW] == '0) ? WW'(1) : weights[i*WW +: WW];
            end
          end
        end
      end
      GRANT: begin
        grant_d = grant_q;
        if (fin_owner) begin
          for (int unsigned i = 0; i < N; i++) begin
            if ((3'(i) == owner_q) && (credit_q[i] != '0)) credit_d[i] = credit_q[i] - 1'b1;
          end
          // Remaining credit after the decrement is nonzero iff it was > 1.
          ptr_d   = (owner_credit > WW'(1)) ? owner_q : next_owner;
          state_d = GAP;
          grant_d = '0;
        end else if (expired) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (3'(i) == owner_q) credit_d[i] = '0;
          end
          ptr_d   = next_owner;
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      for (int unsigned i = 0; i < N; i++) credit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], 1'b1};
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

`ifdef PKT_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;

  // The counter sits at zero outside GRANT, so it starts each packet at zero.
  // It reads TIMEOUT-1 during the TIMEOUT-th GRANT cycle.
  assign expired = (state_q == GRANT) && (wdog_q == CW'(TIMEOUT - 1));

  always_comb begin
    wdog_d    = '0;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      wdog_d    = wdog_q + 1'b1;
      timeout_d = expired && !fin_owner;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign timeout        = 1'b0;
`endif

  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);
  assign grant_id = owner_q;

endmodule

// File: tb/tb_packet_wrr_scheduler.sv
// Self-checking bench for packet_wrr_scheduler.
// The reference model tracks mode, owner, credits and pointer as plain
// integers and applies the arbitration rules once per rising edge. The DUT
// outputs are compared against the model on every falling edge. Directed
// scenarios pin both the model and the DUT with literal grant sequences.
module tb_packet_wrr_scheduler;
  localparam int N  = 4;
  localparam int WW = 3;
  localparam int TO = 16;
`ifdef PKT_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    fin   = '0;
  logic            ready = 1'b0;
  logic [N*WW-1:0] weights = '0;
  logic [N-1:0]    grant;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout;

  packet_wrr_scheduler #(.N(N), .WW(WW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .fin(fin), .ready(ready),
    .weights(weights), .grant(grant), .grant_id(grant_id), .busy(busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: mode 0 = idle, 1 = granted, 2 = gap
  int m_mode, m_owner, m_ptr, m_sync, m_gcyc;
  bit m_to;
  int m_credit[N];
  int mseq[$];      // model grant log, -1 marks a credit reload
  int dseq[$];      // DUT owners observed at each busy rise
  int blen[$];      // DUT busy run lengths
  int to_cnt;
  int run;
  bit busy_prev;
  int auto_len = 0; // when nonzero, the owner fins in its auto_len-th granted cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    bit ok;
    n_checks++;
    ok = (act.size() == exp.size());
    if (ok) foreach (exp[i]) if (act[i] != exp[i]) ok = 1'b0;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %p, expected %p", name, act, exp);
    end
  endtask

  function automatic int wfield(input int i);
    return int'(weights[i*WW +: WW]);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_ptr = 0; m_sync = 0; m_gcyc = 0; m_to = 1'b0;
    for (int i = 0; i < N; i++) m_credit[i] = 0;
  endtask

  task automatic model_step();
    int sel;
    bit ok;
    m_to = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    ok = (m_sync >= 2);
    if (m_sync < 2) m_sync++;
    if (m_mode == 0) begin
      if (ok && ready && (req != '0)) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (sel < 0 && req[i] && m_credit[i] > 0) sel = i;
        end
        if (sel >= 0) begin
          m_mode = 1; m_owner = sel; m_gcyc = 1;
          mseq.push_back(sel);
        end else begin
          for (int i = 0; i < N; i++) m_credit[i] = (wfield(i) == 0) ? 1 : wfield(i);
          mseq.push_back(-1);
        end
      end
    end else if (m_mode == 1) begin
      if (fin[m_owner]) begin
        if (m_credit[m_owner] > 0) m_credit[m_owner]--;
        m_ptr  = (m_credit[m_owner] > 0) ? m_owner : (m_owner + 1) % N;
        m_mode = 2;
      end else if (WD_EN && m_gcyc == TO) begin
        m_credit[m_owner] = 0;
        m_ptr  = (m_owner + 1) % N;
        m_mode = 2;
        m_to   = 1'b1;
      end else begin
        m_gcyc++;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  // model clock process plus automatic fin driver
  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      model_step();
      #2;
      if (auto_len != 0)
        fin = (m_mode == 1 && m_gcyc == auto_len) ? 4'(1 << m_owner) : '0;
    end
  end

  initial forever begin
    @(negedge reset);
    model_reset();
  end

  // per-cycle compare and DUT observation
  initial begin
    to_cnt = 0; run = 0; busy_prev = 1'b0;
    forever begin
      @(negedge clock);
      chk("grant",    32'(grant),    (m_mode == 1) ? 32'(1 << m_owner) : 32'd0);
      chk("busy",     32'(busy),     32'(m_mode == 1));
      chk("grant_id", 32'(grant_id), 32'(m_owner));
      chk("timeout",  32'(timeout),  32'(m_to));
      if (busy && !busy_prev) dseq.push_back(int'(grant_id));
      if (busy) run++;
      else if (busy_prev) begin
        blen.push_back(run);
        run = 0;
      end
      if (timeout) to_cnt++;
      busy_prev = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  task automatic do_reset();
    auto_len = 0; fin = '0; req = '0;
    reset = 1'b0;
    step(2);
    dseq.delete(); mseq.delete(); blen.delete();
    to_cnt = 0; run = 0; busy_prev = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (dseq.size() < n && t < budget) begin
      step(1);
      t++;
    end
    if (dseq.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: got %0d grants, expected %0d within %0d cycles", name, dseq.size(), n, budget);
    end
  endtask

  initial begin
    int e[$];
    ready = 1'b1;
    weights = {3'd1, 3'd1, 3'd1, 3'd1};
    step(3);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);

    // equal weights, all requesting, 5-cycle packets
    do_reset();
    req = 4'b1111; auto_len = 5;
    wait_grants("A", 5, 200);
    e = '{-1, 0, 1, 2, 3, -1, 0}; chk_q("A_model_seq", mseq, e);
    e = '{0, 1, 2, 3, 0};         chk_q("A_dut_seq", dseq, e);
    for (int i = 0; i < 4; i++) chk("A_len", (blen.size() > i) ? 32'(blen[i]) : 32'hffff_ffff, 32'd5);

    // weight 3 on requester 0, 1-cycle packets
    do_reset();
    weights = {3'd1, 3'd1, 3'd1, 3'd3};
    req = 4'b0011; auto_len = 1;
    wait_grants("B", 8, 300);
    req = '0;
    e = '{-1, 0, 0, 0, 1, -1, 0, 0, 0, 1}; chk_q("B_model_seq", mseq, e);
    e = '{0, 0, 0, 1, 0, 0, 0, 1};         chk_q("B_dut_seq", dseq, e);
    chk("B_len", (blen.size() > 0) ? 32'(blen[0]) : 32'hffff_ffff, 32'd1);
    step(4);

    // ready gating then reload + arbitrate latency
    do_reset();
    weights = {3'd1, 3'd1, 3'd1, 3'd1};
    ready = 1'b0; req = 4'b0100;
    step(4);
    chk("C_no_grant_ready0", 32'(grant), 32'd0);
    ready = 1'b1;
    step(1);
    chk("C_reload_cycle", 32'(grant), 32'd0);
    step(1);
    chk("C_grant", 32'(grant), 32'b0100);
    chk("C_grant_id", 32'(grant_id), 32'd2);

    // owner keeps grant despite req drop and a non-owner fin
    req = '0; fin = 4'b0010;
    step(1);
    fin = '0;
    step(3);
    chk("D_hold_grant", 32'(grant), 32'b0100);
    chk("D_hold_busy", 32'(busy), 32'd1);
    fin = 4'b0100;
    step(1);
    fin = '0;
    chk("D_released", 32'(grant), 32'd0);
    chk("D_id_holds", 32'(grant_id), 32'd2);
    step(2);

    // asynchronous reset mid-packet
    do_reset();
    req = 4'b1111; auto_len = 5;
    wait_grants("E", 2, 100);
    step(2);
    reset = 1'b0;
    #1;
    chk("E_async_grant", 32'(grant), 32'd0);
    chk("E_async_busy", 32'(busy), 32'd0);
    step(1);
    dseq.delete(); mseq.delete();
    reset = 1'b1;
    wait_grants("E2", 1, 50);
    e = '{0}; chk_q("E_first_after_reset", dseq, e);
    chk("E_reload_first", (mseq.size() > 0) ? 32'(mseq[0]) : 32'd7, 32'hffff_ffff);
    req = '0;
    step(8);

`ifdef PKT_WATCHDOG_EN
    // owner 2 never fins: watchdog aborts, next grant to 3
    do_reset();
    weights = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b1100; auto_len = 0;
    wait_grants("W", 2, 200);
    req = '0;
    e = '{2, 3}; chk_q("W_seq", dseq, e);
    chk("W_len", (blen.size() > 0) ? 32'(blen[0]) : 32'hffff_ffff, 32'd16);
    chk("W_pulses", 32'(to_cnt), 32'd1);
    step(24);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
